// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus responder: FSM states, HD44780 opcode
// masks, DDRAM line geometry and lcd_control bit positions.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_CLR  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_HOME  = 3'd2,
    CMD_ENTRY = 3'd3,
    CMD_DISP  = 3'd4,
    CMD_FUNC  = 3'd5,
    CMD_CGRAM = 3'd6,
    CMD_DDRAM = 3'd7
  } cmd_e;

  localparam logic [7:0] OP_CLR   = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam int CTL_E  = 0;
  localparam int CTL_RS = 1;
  localparam int CTL_RW = 2;

  // Highest set bit selects the instruction; cursor/display shift is treated as a no-op.
  function automatic cmd_e decode_cmd(input logic [7:0] b);
    cmd_e c;
    if ((b & OP_DDRAM) != 8'h00) begin
      c = CMD_DDRAM;
    end else if ((b & OP_CGRAM) != 8'h00) begin
      c = CMD_CGRAM;
    end else if ((b & OP_FUNC) != 8'h00) begin
      c = CMD_FUNC;
    end else if ((b & OP_SHIFT) != 8'h00) begin
      c = CMD_NOP;
    end else if ((b & OP_DISP) != 8'h00) begin
      c = CMD_DISP;
    end else if ((b & OP_ENTRY) != 8'h00) begin
      c = CMD_ENTRY;
    end else if ((b & OP_HOME) != 8'h00) begin
      c = CMD_HOME;
    end else if ((b & OP_CLR) != 8'h00) begin
      c = CMD_CLEAR;
    end else begin
      c = CMD_NOP;
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// HD44780 address counter arithmetic: 40-char line wrap for the next address,
// and mapping of a DDRAM address onto the 2xCOLS mirror.
module lcd_addr_step
  import lcd_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int IDX_W = $clog2(2 * COLS)
) (
  input  logic [6:0]       addr_i,
  input  logic             inc_i,
  output logic [6:0]       next_o,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [6:0] off_s;

  // Next address with line wrap; out-of-range addresses step modulo 128.
  always_comb begin
    next_o = addr_i;
    if (inc_i) begin
      if (addr_i == LINE1_LAST) begin
        next_o = LINE2_BASE;
      end else if (addr_i == LINE2_LAST) begin
        next_o = LINE1_BASE;
      end else begin
        next_o = addr_i + 7'd1;
      end
    end else begin
      if (addr_i == LINE1_BASE) begin
        next_o = LINE2_LAST;
      end else if (addr_i == LINE2_BASE) begin
        next_o = LINE1_LAST;
      end else begin
        next_o = addr_i - 7'd1;
      end
    end
  end

  // Only the first COLS cells of each line are mirrored.
  always_comb begin
    off_s = addr_i - LINE2_BASE;
    hit_o = 1'b0;
    idx_o = '0;
    if (int'(addr_i) < COLS) begin
      hit_o = 1'b1;
      idx_o = IDX_W'(addr_i);
    end else if ((addr_i >= LINE2_BASE) && (int'(off_s) < COLS)) begin
      hit_o = 1'b1;
      idx_o = IDX_W'(COLS + int'(off_s));
    end else begin
      hit_o = 1'b0;
      idx_o = '0;
    end
  end

endmodule

// File: rtl/lcd_rx_mirror.sv
// Responder for the 4-bit HD44780 bus: detects E falling edges, runs the
// nibble-mode init, assembles bytes, executes them and shadows DDRAM.
module lcd_rx_mirror
  import lcd_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int CLR_CYCLES = 2 * COLS
) (
  input  logic       clk_in,
  input  logic       nClear,
  input  logic [3:0] lcd_dataout,
  input  logic [2:0] lcd_control,
  input  logic [4:0] rd_sel,
  output logic [7:0] rd_data,
  output logic [6:0] ddram_addr,
  output logic [2:0] disp_ctrl,
  output logic       inc_mode,
  output logic       init_done,
  output logic       busy,
  output logic [1:0] err
);

  localparam int DEPTH = 2 * COLS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(CLR_CYCLES + 1);

  rx_state_e        state_q, state_d;
  logic             e_prev_q;
  logic [3:0]       hi_q, hi_d;
  logic             rs_q, rs_d;
  logic [6:0]       addr_q, addr_d;
  logic [2:0]       disp_q, disp_d;
  logic             inc_q, inc_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mirror_q [DEPTH];

  logic             strobe_s, accept_s, rs_in_s, rw_in_s;
  logic [7:0]       byte_s;
  logic             we_s;
  logic [IDX_W-1:0] widx_s;
  logic [7:0]       wdata_s;
  logic [6:0]       next_addr_s;
  logic             hit_s;
  logic [IDX_W-1:0] hit_idx_s;

  lcd_addr_step #(
    .COLS (COLS),
    .IDX_W(IDX_W)
  ) u_addr_step (
    .addr_i(addr_q),
    .inc_i (inc_q),
    .next_o(next_addr_s),
    .hit_o (hit_s),
    .idx_o (hit_idx_s)
  );

  assign rs_in_s  = lcd_control[CTL_RS];
  assign rw_in_s  = lcd_control[CTL_RW];
  assign strobe_s = e_prev_q & ~lcd_control[CTL_E];
  assign accept_s = strobe_s & ~rw_in_s & ~busy_q;
  assign byte_s   = {hi_q, lcd_dataout};

  // Strobe screening, FSM and instruction/data execution.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    rs_d        = rs_q;
    addr_d      = addr_q;
    disp_d      = disp_q;
    inc_d       = inc_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    we_s        = 1'b0;
    widx_s      = '0;
    wdata_s     = BLANK_CHAR;

    if (strobe_s && rw_in_s) begin
      err_d[1] = 1'b1;
    end else if (strobe_s && busy_q) begin
      err_d[0] = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_INIT: begin
        if (accept_s && !rs_in_s && (lcd_dataout == 4'h2)) begin
          state_d     = ST_HI;
          init_done_d = 1'b1;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_HI: begin
        if (accept_s) begin
          hi_d    = lcd_dataout;
          rs_d    = rs_in_s;
          state_d = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (accept_s) begin
          state_d = ST_HI;
          if (rs_q) begin
            we_s    = hit_s;
            widx_s  = hit_idx_s;
            wdata_s = byte_s;
            addr_d  = next_addr_s;
          end else begin
            case (decode_cmd(byte_s))
              CMD_DDRAM: addr_d = byte_s[6:0];
              CMD_DISP:  disp_d = byte_s[2:0];
              CMD_ENTRY: inc_d  = byte_s[1];
              CMD_HOME:  addr_d = LINE1_BASE;
              CMD_CLEAR: begin
                addr_d  = LINE1_BASE;
                inc_d   = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_CLR;
              end
              default:   addr_d = addr_q;
            endcase
          end
        end else begin
          state_d = ST_LO;
        end
      end
      ST_CLR: begin
        // Fill one cell per cycle; cycles beyond the mirror depth just wait.
        we_s   = (int'(cnt_q) < DEPTH);
        widx_s = IDX_W'(cnt_q);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_HI;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk_in) begin
    if (!nClear) begin
      state_q     <= ST_INIT;
      e_prev_q    <= 1'b0;
      hi_q        <= 4'h0;
      rs_q        <= 1'b0;
      addr_q      <= 7'h00;
      disp_q      <= 3'b000;
      inc_q       <= 1'b1;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 2'b00;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      e_prev_q    <= lcd_control[CTL_E];
      hi_q        <= hi_d;
      rs_q        <= rs_d;
      addr_q      <= addr_d;
      disp_q      <= disp_d;
      inc_q       <= inc_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // DDRAM mirror storage.
  always_ff @(posedge clk_in) begin
    if (!nClear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mirror_q[i] <= BLANK_CHAR;
      end
    end else if (we_s) begin
      mirror_q[widx_s] <= wdata_s;
    end else begin
      mirror_q[widx_s] <= mirror_q[widx_s];
    end
  end

  // Combinational read-back port.
  always_comb begin
    rd_data = BLANK_CHAR;
    if (int'(rd_sel) < DEPTH) begin
      rd_data = mirror_q[IDX_W'(rd_sel)];
    end else begin
      rd_data = BLANK_CHAR;
    end
  end

  assign ddram_addr = addr_q;
  assign disp_ctrl  = disp_q;
  assign inc_mode   = inc_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lcd_rx_mirror.sv
// Directed bench for lcd_rx_mirror: drives the 4-bit bus like the lcd master
// and compares status outputs and the mirror against hand-computed values.
module tb_lcd_rx_mirror;

  logic       clk_in = 1'b0;
  logic       nClear;
  logic [3:0] lcd_dataout;
  logic [2:0] lcd_control;
  logic [4:0] rd_sel;
  logic [7:0] rd_data;
  logic [6:0] ddram_addr;
  logic [2:0] disp_ctrl;
  logic       inc_mode;
  logic       init_done;
  logic       busy;
  logic [1:0] err;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_mem [32];

  always #5 clk_in = ~clk_in;

  lcd_rx_mirror #(.COLS(16), .CLR_CYCLES(32)) dut (
    .clk_in     (clk_in),
    .nClear     (nClear),
    .lcd_dataout(lcd_dataout),
    .lcd_control(lcd_control),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .ddram_addr (ddram_addr),
    .disp_ctrl  (disp_ctrl),
    .inc_mode   (inc_mode),
    .init_done  (init_done),
    .busy       (busy),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One E pulse; returns at the negedge after the update edge.
  task automatic pulse(input logic [3:0] nib, input logic rs, input logic rw);
    @(negedge clk_in);
    lcd_dataout = nib;
    lcd_control = {rw, rs, 1'b1};
    @(negedge clk_in);
    lcd_control = {rw, rs, 1'b0};
    @(negedge clk_in);
    lcd_control = 3'b000;
    lcd_dataout = 4'h0;
  endtask

  task automatic send(input logic [7:0] b, input logic rs);
    pulse(b[7:4], rs, 1'b0);
    pulse(b[3:0], rs, 1'b0);
  endtask

  task automatic rd_check(input string tag, input int idx, input logic [7:0] exp);
    rd_sel = 5'(idx);
    #1;
    check_eq(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic mem_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_sel = 5'(i);
      #1;
      if (rd_data !== exp_mem[i]) bad++;
    end
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  task automatic blank_model();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
  endtask

  initial begin
    int cyc;
    nClear      = 1'b0;
    lcd_dataout = 4'h0;
    lcd_control = 3'b000;
    rd_sel      = 5'd0;
    blank_model();
    repeat (3) @(negedge clk_in);
    nClear = 1'b1;

    check_eq("rst_init_done", {31'h0, init_done}, 32'd0);
    check_eq("rst_addr", {25'h0, ddram_addr}, 32'h00);
    check_eq("rst_disp", {29'h0, disp_ctrl}, 32'd0);
    check_eq("rst_inc", {31'h0, inc_mode}, 32'd1);
    check_eq("rst_busy_err", {29'h0, busy, err}, 32'd0);
    mem_check("rst_mirror");

    pulse(4'h3, 1'b0, 1'b0);
    pulse(4'h3, 1'b0, 1'b0);
    pulse(4'h3, 1'b0, 1'b0);
    check_eq("init_after_3s", {31'h0, init_done}, 32'd0);
    pulse(4'h2, 1'b0, 1'b0);
    check_eq("init_after_2", {31'h0, init_done}, 32'd1);

    send(8'h28, 1'b0);
    send(8'h06, 1'b0);
    check_eq("entry_inc", {31'h0, inc_mode}, 32'd1);
    send(8'h0C, 1'b0);
    check_eq("disp_on", {29'h0, disp_ctrl}, 32'b100);
    send(8'h01, 1'b0);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk_in);
    end
    check_eq("clr_busy_cycles", 32'(cyc), 32'd32);
    check_eq("clr_addr", {25'h0, ddram_addr}, 32'h00);
    mem_check("clr_mirror");

    send(8'h80, 1'b0);
    send(8'h48, 1'b1);
    send(8'h69, 1'b1);
    exp_mem[0] = 8'h48;
    exp_mem[1] = 8'h69;
    rd_check("rd0_H", 0, 8'h48);
    rd_check("rd1_i", 1, 8'h69);
    check_eq("addr_after_Hi", {25'h0, ddram_addr}, 32'h02);

    send(8'hC0, 1'b0);
    send(8'h41, 1'b1);
    exp_mem[16] = 8'h41;
    rd_check("rd16_A", 16, 8'h41);
    check_eq("addr_0x41", {25'h0, ddram_addr}, 32'h41);
    send(8'hA7, 1'b0);
    send(8'h42, 1'b1);
    check_eq("wrap_27_40", {25'h0, ddram_addr}, 32'h40);
    mem_check("offscreen_no_write");
    send(8'hE7, 1'b0);
    send(8'h43, 1'b1);
    check_eq("wrap_67_00", {25'h0, ddram_addr}, 32'h00);

    send(8'h04, 1'b0);
    check_eq("entry_dec", {31'h0, inc_mode}, 32'd0);
    send(8'h80, 1'b0);
    send(8'h5A, 1'b1);
    exp_mem[0] = 8'h5A;
    rd_check("rd0_Z", 0, 8'h5A);
    check_eq("wrap_00_67", {25'h0, ddram_addr}, 32'h67);
    send(8'hC0, 1'b0);
    send(8'h30, 1'b1);
    exp_mem[16] = 8'h30;
    check_eq("wrap_40_27", {25'h0, ddram_addr}, 32'h27);
    mem_check("dec_mirror");

    send(8'h01, 1'b0);
    repeat (4) @(negedge clk_in);
    pulse(4'h5, 1'b1, 1'b0);
    check_eq("busy_drop_err", {30'h0, err}, 32'b01);
    check_eq("busy_still", {31'h0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk_in);
    end
    check_eq("busy_fell", {31'h0, busy}, 32'd0);
    blank_model();
    check_eq("clr_inc_forced", {31'h0, inc_mode}, 32'd1);
    send(8'h33, 1'b1);
    exp_mem[0] = 8'h33;
    rd_check("post_clr_write", 0, 8'h33);
    check_eq("post_clr_addr", {25'h0, ddram_addr}, 32'h01);

    pulse(4'h7, 1'b1, 1'b1);
    check_eq("rw_err", {30'h0, err}, 32'b11);
    send(8'h44, 1'b1);
    exp_mem[1] = 8'h44;
    rd_check("after_rw_write", 1, 8'h44);
    mem_check("after_rw_mirror");

    pulse(4'h4, 1'b1, 1'b0);
    @(negedge clk_in);
    nClear = 1'b0;
    @(negedge clk_in);
    nClear = 1'b1;
    blank_model();
    check_eq("midrst_init_done", {31'h0, init_done}, 32'd0);
    check_eq("midrst_err", {30'h0, err}, 32'd0);
    check_eq("midrst_addr", {25'h0, ddram_addr}, 32'h00);
    mem_check("midrst_mirror");
    pulse(4'h2, 1'b0, 1'b0);
    check_eq("midrst_reinit", {31'h0, init_done}, 32'd1);
    send(8'h41, 1'b1);
    exp_mem[0] = 8'h41;
    rd_check("midrst_write", 0, 8'h41);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
